gapb_mst_if: RTL and testbench



---
 rtl/gapb_pkg.sv | 13 +
 rtl/gapb_mst_if_if.sv | 40 ++++
 rtl/gapb_mst_tmo.sv | 37 +++
 rtl/gapb_mst_if.sv | 126 ++++++++++++
 tb/tb_gapb_mst_if.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gapb_pkg.sv
// Shared APB definitions: phase-state encoding and data width.
// Also used by the APB register-interface blocks.
package gapb_pkg;

  localparam int GAPB_DATA_W = 32;

  typedef enum logic [1:0] {
    GAPB_IDLE   = 2'b00,
    GAPB_SETUP  = 2'b01,
    GAPB_ACCESS = 2'b10
  } gapb_state_e;

endpackage

// File: rtl/gapb_mst_if_if.sv
// Request/response and APB bus bundle for the APB requester.
// The master modport is the requester's view; the slave modport is the view
// of whatever sits on the other side (engine plus APB target).
interface gapb_mst_if_if import gapb_pkg::*; #(
  parameter int ADDR_WIDTH = 8
);

  // Engine-side request/response
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [GAPB_DATA_W-1:0] req_wdata;
  logic                   rsp_valid;
  logic [GAPB_DATA_W-1:0] rsp_rdata;
  logic                   rsp_err;
  logic                   busy;

  // APB bus
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [ADDR_WIDTH-1:0]  paddr;
  logic [GAPB_DATA_W-1:0] pwdata;
  logic [GAPB_DATA_W-1:0] prdata;
  logic                   pready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/gapb_mst_tmo.sv
// ACCESS-phase wait counter for the APB requester. Counts ACCESS cycles
// that see pready low and flags the cycle on which the transfer must be
// forced to end. Only built when GAPB_MST_PREADY_EN is defined.
module gapb_mst_tmo #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic in_access_i,
  input  logic pready_i,
  output logic timeout_hit_o
);

  logic [7:0] count_q, count_d;

  // Outside ACCESS the count sits at zero, so every ACCESS starts fresh.
  always_comb begin
    count_d = count_q;
    if (!in_access_i) begin
      count_d = '0;
    end else if (!pready_i) begin
      count_d = count_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout_hit_o = in_access_i && (count_q == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/gapb_mst_if.sv
// APB requester: turns a single-outstanding request/response interface into
// APB SETUP/ACCESS transfers. Define GAPB_MST_PREADY_EN to honour pready
// with a bounded wait (timeout reported via rsp_err); otherwise ACCESS is
// always one cycle and pready is ignored.
module gapb_mst_if import gapb_pkg::*; #(
  parameter int ADDR_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input logic            pclk,
  input logic            rst_n,
  gapb_mst_if_if.master  bus
);

  gapb_state_e            state_q, state_d;
  logic                   req_ready;
  logic                   accept;
  logic                   complete;
  logic                   timeout_hit;
  logic                   done;
  logic                   psel_q, penable_q, pwrite_q, rsp_valid_q;
  logic [ADDR_WIDTH-1:0]  paddr_q;
  logic [GAPB_DATA_W-1:0] pwdata_q, rsp_rdata_q;

`ifdef GAPB_MST_PREADY_EN
  logic rsp_err_q;

  gapb_mst_tmo #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .in_access_i   (state_q == GAPB_ACCESS),
    .pready_i      (bus.pready),
    .timeout_hit_o (timeout_hit)
  );

  assign complete = bus.pready | timeout_hit;

  // Error flag travels with the response pulse.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= done & timeout_hit;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  logic unused_pready;

  assign unused_pready = bus.pready;
  assign timeout_hit   = 1'b0;
  assign complete      = 1'b1;
  assign bus.rsp_err   = 1'b0;
`endif

  assign accept = bus.req_valid & req_ready;
  assign done   = (state_q == GAPB_ACCESS) & complete;

  // Next phase and request acceptance; a new request can be taken in the
  // same cycle an ACCESS completes, giving back-to-back transfers.
  always_comb begin
    state_d   = state_q;
    req_ready = (state_q == GAPB_IDLE) | ((state_q == GAPB_ACCESS) & complete);
    case (state_q)
      GAPB_IDLE:   if (accept) state_d = GAPB_SETUP;
      GAPB_SETUP:  state_d = GAPB_ACCESS;
      GAPB_ACCESS: if (complete) state_d = accept ? GAPB_SETUP : GAPB_IDLE;
      default:     state_d = GAPB_IDLE;
    endcase
  end

  // Phase register; psel/penable are decoded from the next phase so they
  // come straight out of flops.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= GAPB_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= (state_d != GAPB_IDLE);
      penable_q <= (state_d == GAPB_ACCESS);
    end
  end

  // Address/data/direction latch on accept and hold until the next accept.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (accept) begin
      pwrite_q <= bus.req_write;
      paddr_q  <= bus.req_addr;
      pwdata_q <= bus.req_wdata;
    end
  end

  // Response pulse and read-data capture on the completing ACCESS edge.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= done;
      if (done & timeout_hit) begin
        rsp_rdata_q <= '0;
      end else if (done & ~pwrite_q) begin
        rsp_rdata_q <= bus.prdata;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = (state_q != GAPB_IDLE);
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_gapb_mst_if.sv
// Bench for gapb_mst_if. A transaction scheduler fills per-cycle stimulus
// and expectation tables; one process drives inputs after each rising edge
// and another compares every output on the falling edge.
`timescale 1ns/1ps
module tb_gapb_mst_if;

  localparam int AW      = 8;
  localparam int TMO     = 16;
  localparam int MAXC    = 128;
  localparam int END_CYC = 96;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_free = 0;

  always #5 pclk = ~pclk;

  gapb_mst_if_if #(.ADDR_WIDTH(AW)) bus();

  gapb_mst_if #(.ADDR_WIDTH(AW), .TIMEOUT_CYC(TMO)) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Per-cycle stimulus
  logic          drv_rst    [MAXC];
  logic          drv_rv     [MAXC];
  logic          drv_wr     [MAXC];
  logic [AW-1:0] drv_addr   [MAXC];
  logic [31:0]   drv_wdata  [MAXC];
  logic          drv_pready [MAXC];
  logic [31:0]   drv_prdata [MAXC];
  // Per-cycle expectations
  logic          exp_ready  [MAXC];
  logic          exp_psel   [MAXC];
  logic          exp_pen    [MAXC];
  logic          exp_busy   [MAXC];
  logic          exp_rv     [MAXC];
  logic          exp_err    [MAXC];
  logic [31:0]   exp_rdata  [MAXC];
  logic          exp_pwrite [MAXC];
  logic [AW-1:0] exp_paddr  [MAXC];
  logic [31:0]   exp_pwdata [MAXC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  task automatic model_init();
    for (int c = 0; c < MAXC; c++) begin
      drv_rst[c]    = (c >= 4);
      drv_rv[c]     = 1'b0;
      drv_wr[c]     = 1'b0;
      drv_addr[c]   = '0;
      drv_wdata[c]  = '0;
      drv_pready[c] = 1'b1;
      drv_prdata[c] = 32'hBAD0_0000 | 32'(c);
      exp_ready[c]  = 1'b1;
      exp_psel[c]   = 1'b0;
      exp_pen[c]    = 1'b0;
      exp_busy[c]   = 1'b0;
      exp_rv[c]     = 1'b0;
      exp_err[c]    = 1'b0;
      exp_rdata[c]  = '0;
      exp_pwrite[c] = 1'b0;
      exp_paddr[c]  = '0;
      exp_pwdata[c] = '0;
    end
  endtask

  // Reset held low for cycles c0..c1-1: everything from c0 returns to reset
  // values and anything in flight is forgotten.
  task automatic model_reset(input int c0, input int c1);
    for (int c = c0; c < MAXC; c++) begin
      drv_rst[c]    = (c >= c1);
      drv_rv[c]     = 1'b0;
      drv_pready[c] = 1'b1;
      exp_ready[c]  = 1'b1;
      exp_psel[c]   = 1'b0;
      exp_pen[c]    = 1'b0;
      exp_busy[c]   = 1'b0;
      exp_rv[c]     = 1'b0;
      exp_err[c]    = 1'b0;
      exp_rdata[c]  = '0;
      exp_pwrite[c] = 1'b0;
      exp_paddr[c]  = '0;
      exp_pwdata[c] = '0;
    end
    m_free = c1;
  endtask

  // Request presented from cycle p and held until taken. w = pready-low
  // cycles before pready rises in ACCESS; w < 0 means pready never rises.
  // Returns the edge index a at which the request is taken.
  task automatic sched(input int p, input bit wr, input logic [AW-1:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int w, output int a);
    int L;
    bit tmo;
`ifdef GAPB_MST_PREADY_EN
    tmo = (w < 0);
    L   = tmo ? TMO : w + 1;
`else
    tmo = 1'b0;
    L   = 1;
`endif
    a = ((p > m_free) ? p : m_free) + 1;
    for (int c = p; c < a; c++) begin
      drv_rv[c] = 1'b1; drv_wr[c] = wr; drv_addr[c] = addr; drv_wdata[c] = wd;
    end
    for (int c = a; c <= a + L; c++) begin
      exp_psel[c] = 1'b1; exp_busy[c] = 1'b1;
    end
    for (int c = a; c < a + L; c++) exp_ready[c] = 1'b0;
    for (int c = a + 1; c <= a + L; c++) begin
      exp_pen[c]    = 1'b1;
      drv_pready[c] = ((c - a - 1) == w);
    end
    drv_prdata[a + L] = rd;
    exp_rv[a + L + 1]  = 1'b1;
    exp_err[a + L + 1] = tmo;
    for (int c = a; c < MAXC; c++) begin
      exp_pwrite[c] = wr; exp_paddr[c] = addr; exp_pwdata[c] = wd;
    end
    if (tmo || !wr)
      for (int c = a + L + 1; c < MAXC; c++) exp_rdata[c] = tmo ? 32'h0 : rd;
    m_free = a + L;
  endtask

  task automatic apply(input int c);
    rst_n         = drv_rst[c];
    bus.req_valid = drv_rv[c];
    bus.req_write = drv_wr[c];
    bus.req_addr  = drv_addr[c];
    bus.req_wdata = drv_wdata[c];
    bus.pready    = drv_pready[c];
    bus.prdata    = drv_prdata[c];
  endtask

  // Stimulus schedule, then drive until the end cycle.
  initial begin
    int a;
    model_init();
    sched(6,  1'b1, 8'h05, 32'hA5A5_0001, 32'h0, 0, a);
    sched(12, 1'b0, 8'h03, 32'h0, 32'h1234_5678, 0, a);
    sched(20, 1'b1, 8'h00, 32'h1111_0000, 32'h0, 0, a);
    sched(a,  1'b0, 8'h01, 32'h0, 32'hCAFE_0001, 0, a);
    sched(a,  1'b1, 8'h02, 32'h3333_2222, 32'h0, 0, a);
    sched(a,  1'b0, 8'h03, 32'h0, 32'hCAFE_0003, 0, a);
    sched(34, 1'b1, 8'h0A, 32'h5555_AAAA, 32'h0, 0, a);
    model_reset(36, 38);
    sched(41, 1'b0, 8'h07, 32'h0, 32'h0F0F_0F0F, 0, a);
    sched(50, 1'b1, 8'h11, 32'hDEAD_BEEF, 32'h0, 3, a);
    sched(60, 1'b0, 8'h22, 32'h0, 32'h9999_9999, -1, a);
    apply(0);
    while (cyc < END_CYC) begin
      @(posedge pclk);
      cyc++;
      #1;
      apply(cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Output comparison against the tables, plus hand-derived spot values.
  always @(negedge pclk) begin
    if (cyc >= 1 && cyc < END_CYC) begin
      chk("req_ready", bus.req_ready, exp_ready[cyc]);
      chk("psel",      bus.psel,      exp_psel[cyc]);
      chk("penable",   bus.penable,   exp_pen[cyc]);
      chk("busy",      bus.busy,      exp_busy[cyc]);
      chk("rsp_valid", bus.rsp_valid, exp_rv[cyc]);
      chk("rsp_err",   bus.rsp_err,   exp_err[cyc]);
      chk("rsp_rdata", bus.rsp_rdata, exp_rdata[cyc]);
      chk("pwrite",    bus.pwrite,    exp_pwrite[cyc]);
      chk("paddr",     32'(bus.paddr), 32'(exp_paddr[cyc]));
      chk("pwdata",    bus.pwdata,    exp_pwdata[cyc]);

      if (cyc == 7) begin
        chk("lit_wr_setup_psel", bus.psel, 1);
        chk("lit_wr_setup_pen", bus.penable, 0);
        chk("lit_wr_setup_pwrite", bus.pwrite, 1);
        chk("lit_wr_setup_paddr", 32'(bus.paddr), 32'h05);
        chk("lit_wr_setup_pwdata", bus.pwdata, 32'hA5A5_0001);
      end
      if (cyc == 8) chk("lit_wr_access_pen", bus.penable, 1);
      if (cyc == 9) begin
        chk("lit_wr_rsp_valid", bus.rsp_valid, 1);
        chk("lit_wr_rsp_psel", bus.psel, 0);
      end
      if (cyc == 15) begin
        chk("lit_rd_rsp_valid", bus.rsp_valid, 1);
        chk("lit_rd_rdata", bus.rsp_rdata, 32'h1234_5678);
      end
      if (cyc >= 21 && cyc <= 28) begin
        chk("lit_b2b_psel", bus.psel, 1);
        chk("lit_b2b_pen", bus.penable, 32'((cyc % 2) == 0));
        chk("lit_b2b_ready", bus.req_ready, 32'((cyc % 2) == 0));
      end
      if (cyc >= 23 && cyc <= 29) chk("lit_b2b_rsp", bus.rsp_valid, 32'((cyc % 2) == 1));
      if (cyc == 25) chk("lit_b2b_rdata1", bus.rsp_rdata, 32'hCAFE_0001);
      if (cyc == 29) chk("lit_b2b_rdata3", bus.rsp_rdata, 32'hCAFE_0003);
      if (cyc == 36) begin
        chk("lit_rst_psel", bus.psel, 0);
        chk("lit_rst_pen", bus.penable, 0);
      end
      if (cyc >= 37 && cyc <= 40) chk("lit_rst_no_rsp", bus.rsp_valid, 0);
      if (cyc == 42) begin
        chk("lit_post_rst_psel", bus.psel, 1);
        chk("lit_post_rst_pen", bus.penable, 0);
        chk("lit_post_rst_paddr", 32'(bus.paddr), 32'h07);
      end
      if (cyc == 44) chk("lit_post_rst_rdata", bus.rsp_rdata, 32'h0F0F_0F0F);
`ifdef GAPB_MST_PREADY_EN
      if (cyc >= 52 && cyc <= 55) begin
        chk("lit_wait_pen", bus.penable, 1);
        chk("lit_wait_paddr", 32'(bus.paddr), 32'h11);
        chk("lit_wait_pwdata", bus.pwdata, 32'hDEAD_BEEF);
      end
      if (cyc == 56) begin
        chk("lit_wait_rsp", bus.rsp_valid, 1);
        chk("lit_wait_err", bus.rsp_err, 0);
      end
      if (cyc == 77) chk("lit_tmo_last_access", bus.penable, 1);
      if (cyc == 78) begin
        chk("lit_tmo_rsp", bus.rsp_valid, 1);
        chk("lit_tmo_err", bus.rsp_err, 1);
        chk("lit_tmo_rdata", bus.rsp_rdata, 0);
        chk("lit_tmo_psel", bus.psel, 0);
      end
`else
      if (cyc == 53) chk("lit_nowait_rsp", bus.rsp_valid, 1);
      if (cyc == 63) begin
        chk("lit_nowait_rd_rsp", bus.rsp_valid, 1);
        chk("lit_nowait_rd_err", bus.rsp_err, 0);
        chk("lit_nowait_rdata", bus.rsp_rdata, 32'h9999_9999);
      end
`endif
    end
  end

endmodule
